// File: rtl/free_list_pkg.sv
// Shared types and constants for the slot free-list allocator and its
// readers in the redundancy datapath.
package free_list_pkg;

  localparam int WORD_WIDTH = 8;
  localparam int ITER_WIDTH = 9;
  localparam int DIST_WIDTH = 7;
  localparam int STEP_RANGE = 128;

  localparam int SEL_FIXED = 0;
  localparam int SEL_RR    = 1;

  typedef logic [DIST_WIDTH-1:0] slot_t;
  typedef logic [ITER_WIDTH-1:0] tag_t;
  typedef logic [WORD_WIDTH-1:0] word_t;

endpackage

// File: rtl/leading_one_select.sv
// Combinational lowest-index set-bit finder: one-hot, binary index and
// an any-bit flag.
module leading_one_select #(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [W-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/free_list_allocator.sv
// Slot free-list: grants one free, enabled slot per request, stores a tag and
// word per slot, supports release, occupancy count and a registered read port.
module free_list_allocator #(
  parameter int WORD_WIDTH = free_list_pkg::WORD_WIDTH,
  parameter int ITER_WIDTH = free_list_pkg::ITER_WIDTH,
  parameter int DIST_WIDTH = free_list_pkg::DIST_WIDTH,
  parameter int STEP_RANGE = free_list_pkg::STEP_RANGE,
  parameter int RR_MODE    = free_list_pkg::SEL_FIXED
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [STEP_RANGE-1:0] enable_in,
  input  logic                  alloc_req,
  input  logic [ITER_WIDTH-1:0] alloc_it,
  input  logic [WORD_WIDTH-1:0] alloc_src,
  output logic                  alloc_ready,
  output logic                  grant_valid,
  output logic [DIST_WIDTH-1:0] grant_slot,
  input  logic                  release_en,
  input  logic [DIST_WIDTH-1:0] release_slot,
  output logic                  release_err,
  input  logic [DIST_WIDTH-1:0] rd_slot,
  output logic                  valid,
  output logic [ITER_WIDTH-1:0] src_it,
  output logic [WORD_WIDTH-1:0] src,
  output logic [STEP_RANGE-1:0] full,
  output logic [DIST_WIDTH:0]   count
);
  import free_list_pkg::*;

  logic [STEP_RANGE-1:0] cand, sel_oh, oh_all, rel_oh;
  logic [DIST_WIDTH-1:0] sel_idx, idx_all;
  logic                  accept, rel_ok, rel_bad;

  logic [ITER_WIDTH-1:0] it_mem  [STEP_RANGE];
  logic [WORD_WIDTH-1:0] src_mem [STEP_RANGE];

  assign cand    = ~full & enable_in;
  assign accept  = alloc_req & alloc_ready;
  assign rel_ok  = release_en & full[release_slot];
  assign rel_bad = release_en & ~full[release_slot];
  assign rel_oh  = rel_ok ? (STEP_RANGE'(1) << release_slot) : '0;

  leading_one_select #(.W(STEP_RANGE), .IW(DIST_WIDTH)) u_sel_all (
    .vec    (cand),
    .onehot (oh_all),
    .idx    (idx_all),
    .any    (alloc_ready)
  );

  generate
    if (RR_MODE == SEL_RR) begin : g_rr
      logic [DIST_WIDTH-1:0] ptr;
      logic [STEP_RANGE-1:0] mask_hi, oh_hi;
      logic [DIST_WIDTH-1:0] idx_hi;
      logic                  any_hi;

      always_comb begin
        mask_hi = '0;
        for (int i = 0; i < STEP_RANGE; i++) mask_hi[i] = (DIST_WIDTH'(i) > ptr);
      end

      leading_one_select #(.W(STEP_RANGE), .IW(DIST_WIDTH)) u_sel_hi (
        .vec    (cand & mask_hi),
        .onehot (oh_hi),
        .idx    (idx_hi),
        .any    (any_hi)
      );

      // Nothing above ptr means the lowest free index is the wrapped successor.
      assign sel_oh  = any_hi ? oh_hi  : oh_all;
      assign sel_idx = any_hi ? idx_hi : idx_all;

      always_ff @(posedge clk) begin
        if (reset)       ptr <= '0;
        else if (accept) ptr <= sel_idx;
      end
    end else begin : g_fixed
      assign sel_oh  = oh_all;
      assign sel_idx = idx_all;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      full        <= '0;
      count       <= '0;
      grant_valid <= 1'b0;
      grant_slot  <= '0;
      release_err <= 1'b0;
      valid       <= 1'b0;
      src_it      <= '0;
      src         <= '0;
    end else begin
      // Selection came from the pre-release vector, so sel_oh and rel_oh never overlap.
      full        <= (full & ~rel_oh) | (accept ? sel_oh : '0);
      count       <= count + (DIST_WIDTH+1)'(accept) - (DIST_WIDTH+1)'(rel_ok);
      grant_valid <= accept;
      if (accept) grant_slot <= sel_idx;
      release_err <= rel_bad;
      valid       <= full[rd_slot];
      src_it      <= it_mem[rd_slot];
      src         <= src_mem[rd_slot];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      it_mem[sel_idx]  <= alloc_it;
      src_mem[sel_idx] <= alloc_src;
    end
  end

endmodule

// File: tb/tb_free_list_allocator.sv
// Scoreboard bench: fixed-priority and round-robin instances share stimulus and
// are checked against a queue-fed reference model.
module tb_free_list_allocator;
  import free_list_pkg::*;

  localparam int N = STEP_RANGE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [N-1:0] en;
  logic         req;
  tag_t         it;
  word_t        sw;
  logic         rel_en;
  slot_t        rel_slot, rd;

  logic              ar   [2];
  logic              gv   [2];
  slot_t             gs   [2];
  logic              rerr [2];
  logic              vld  [2];
  tag_t              sit  [2];
  word_t             ssrc [2];
  logic [N-1:0]      fullv[2];
  logic [DIST_WIDTH:0] cnt[2];

  free_list_allocator #(.RR_MODE(SEL_FIXED)) u_fix (
    .clk(clk), .reset(reset), .enable_in(en), .alloc_req(req), .alloc_it(it),
    .alloc_src(sw), .alloc_ready(ar[0]), .grant_valid(gv[0]), .grant_slot(gs[0]),
    .release_en(rel_en), .release_slot(rel_slot), .release_err(rerr[0]),
    .rd_slot(rd), .valid(vld[0]), .src_it(sit[0]), .src(ssrc[0]),
    .full(fullv[0]), .count(cnt[0]));

  free_list_allocator #(.RR_MODE(SEL_RR)) u_rr (
    .clk(clk), .reset(reset), .enable_in(en), .alloc_req(req), .alloc_it(it),
    .alloc_src(sw), .alloc_ready(ar[1]), .grant_valid(gv[1]), .grant_slot(gs[1]),
    .release_en(rel_en), .release_slot(rel_slot), .release_err(rerr[1]),
    .rd_slot(rd), .valid(vld[1]), .src_it(sit[1]), .src(ssrc[1]),
    .full(fullv[1]), .count(cnt[1]));

  // Reference model: per-instance occupancy, contents and last grant.
  bit    occ [2][N];
  bit    wr  [2][N];
  tag_t  mtag[2][N];
  word_t mwrd[2][N];
  int    ptr [2];
  slot_t lgs [2];

  typedef struct {
    int                  d;
    logic                gv;
    slot_t               gs;
    logic                rerr;
    logic                vld;
    logic                chk_rd;
    tag_t                it;
    word_t               src;
    logic [N-1:0]        full;
    logic [DIST_WIDTH:0] cnt;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int d, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Spec rule: scan indices ptr+1, ptr+2, ... modulo N (or 0.. for fixed).
  function automatic int pick(input int d, input bit cand[N], input int mode);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (mode == SEL_RR) ? (ptr[d] + 1 + k) % N : k;
      if (cand[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input int d, input int mode);
    bit   cand[N];
    bit   ready;
    int   s, sum;
    exp_t e;
    ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand[i] = !occ[d][i] && en[i];
      if (cand[i]) ready = 1'b1;
    end
    e = '{default: '0};
    e.d = d;
    if (reset) begin
      for (int i = 0; i < N; i++) occ[d][i] = 1'b0;
      ptr[d] = 0;
      lgs[d] = '0;
      e.chk_rd = 1'b1;
    end else begin
      chk("alloc_ready", d, N'(ar[d]), N'(ready));
      s = pick(d, cand, mode);
      e.vld    = occ[d][rd];
      e.chk_rd = wr[d][rd];
      e.it     = mtag[d][rd];
      e.src    = mwrd[d][rd];
      e.rerr   = rel_en && !occ[d][rel_slot];
      if (rel_en && occ[d][rel_slot]) occ[d][rel_slot] = 1'b0;
      if (req && ready) begin
        occ[d][s]  = 1'b1;
        wr[d][s]   = 1'b1;
        mtag[d][s] = it;
        mwrd[d][s] = sw;
        ptr[d]     = s;
        lgs[d]     = slot_t'(s);
      end
      e.gv = req && ready;
      e.gs = lgs[d];
      sum = 0;
      for (int i = 0; i < N; i++) begin
        e.full[i] = occ[d][i];
        sum += int'(occ[d][i]);
      end
      e.cnt = (DIST_WIDTH+1)'(sum);
    end
    q.push_back(e);
  endtask

  // Inputs are driven just after a falling edge; the model runs once they settle.
  task automatic tick();
    #1;
    model_step(0, SEL_FIXED);
    model_step(1, SEL_RR);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk("grant_valid", e.d, N'(gv[e.d]),   N'(e.gv));
      chk("grant_slot",  e.d, N'(gs[e.d]),   N'(e.gs));
      chk("release_err", e.d, N'(rerr[e.d]), N'(e.rerr));
      chk("valid",       e.d, N'(vld[e.d]),  N'(e.vld));
      chk("full",        e.d, fullv[e.d],    e.full);
      chk("count",       e.d, N'(cnt[e.d]),  N'(e.cnt));
      if (e.chk_rd) begin
        chk("src_it", e.d, N'(sit[e.d]),  N'(e.it));
        chk("src",    e.d, N'(ssrc[e.d]), N'(e.src));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; req = 1'b0; rel_en = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic fill();
    req = 1'b1;
    repeat (N) begin
      it = tag_t'($urandom); sw = word_t'($urandom);
      tick();
    end
    req = 1'b0;
  endtask

  initial begin
    en = '1; req = 1'b0; it = '0; sw = '0; rel_en = 1'b0; rel_slot = '0; rd = '0;
    do_reset();

    // three back-to-back grants, then read back slot 1
    req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      it = tag_t'(5 + k); sw = word_t'(8'h40 + k);
      tick();
    end
    req = 1'b0; rd = slot_t'(1);
    tick(); tick();

    // fill to capacity, extra requests while full, release 40 with a request
    fill();
    req = 1'b1; tick(); tick();
    rel_en = 1'b1; rel_slot = slot_t'(40); tick();
    rel_en = 1'b0; tick();
    req = 1'b0; rd = slot_t'(40); tick(); tick();

    // only slot 99 enabled
    do_reset();
    en = '0; en[99] = 1'b1;
    req = 1'b1; tick(); tick();
    req = 1'b0; tick();
    en = '1;

    // round-robin advances past a just-released slot
    do_reset();
    req = 1'b1; tick();
    req = 1'b0; rel_en = 1'b1; rel_slot = '0; tick();
    rel_en = 1'b0; req = 1'b1; tick();
    req = 1'b0; tick();

    // wrap cases: ptr at N-1 with only N-1 free, then only 0 free
    do_reset();
    fill();
    rel_en = 1'b1; rel_slot = slot_t'(N - 1); tick();
    rel_en = 1'b0; req = 1'b1; tick();
    req = 1'b0; rel_en = 1'b1; rel_slot = '0; tick();
    rel_en = 1'b0; req = 1'b1; tick();
    req = 1'b0; tick();

    // release of a free slot
    do_reset();
    rel_en = 1'b1; rel_slot = slot_t'(10); tick();
    rel_en = 1'b0; tick();

    // reset lands on a grant cycle with five slots held
    do_reset();
    req = 1'b1; repeat (5) tick();
    reset = 1'b1; tick();
    reset = 1'b0; req = 1'b0; tick();

    // randomized traffic
    repeat (3000) begin
      reset    = ($urandom_range(0, 199) == 0);
      req      = ($urandom_range(0, 3) != 0);
      it       = tag_t'($urandom);
      sw       = word_t'($urandom);
      rel_en   = ($urandom_range(0, 2) == 0);
      rel_slot = slot_t'($urandom);
      rd       = slot_t'($urandom);
      en       = ($urandom_range(0, 9) == 0) ? {4{$urandom}} : '1;
      tick();
    end

    reset = 1'b0; req = 1'b0; rel_en = 1'b0;
    tick();
    @(posedge clk); #2;
    chk("scoreboard_drain", 0, N'(q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/free_list_allocator.md
Name: free_list_allocator

Overview:
Parametrised successor to the single-slot free-list controller. Tracks occupancy of STEP_RANGE slots, grants one free, enabled slot per cycle through a req/grant handshake, and stores an iteration tag and source word per slot. Supports explicit release, occupancy count, and fixed-priority or round-robin selection. Feeds the redundancy datapath, which reads back (src_it, src) by slot index.

Parameters:
WORD_WIDTH, 8, width of the stored source word
ITER_WIDTH, 9, width of the stored iteration tag
DIST_WIDTH, 7, slot index width; must equal clog2(STEP_RANGE)
STEP_RANGE, 128, number of slots
RR_MODE, 0, 0 = lowest free index wins; 1 = round-robin starting after the last granted slot

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
enable_in  in  STEP_RANGE  per-slot eligibility mask; slot i is allocatable only if enable_in[i]=1
alloc_req  in  1  allocation request
alloc_it  in  ITER_WIDTH  tag written into the granted slot
alloc_src  in  WORD_WIDTH  word written into the granted slot
alloc_ready  out  1  combinational: at least one slot is free and enabled
grant_valid  out  1  registered: the allocation accepted last cycle is complete
grant_slot  out  DIST_WIDTH  registered: index granted; holds its value when grant_valid=0
release_en  in  1  free the slot named by release_slot
release_slot  in  DIST_WIDTH  slot to free
release_err  out  1  registered pulse: release targeted an already-free slot
rd_slot  in  DIST_WIDTH  read index
valid  out  1  registered: full[rd_slot] as sampled last cycle
src_it  out  ITER_WIDTH  registered tag of rd_slot
src  out  WORD_WIDTH  registered word of rd_slot
full  out  STEP_RANGE  registered occupancy vector
count  out  DIST_WIDTH+1  registered number of occupied slots

Behaviour:
- Reset (synchronous, high): full=0, count=0, grant_valid=0, grant_slot=0, release_err=0, valid=0, src_it=0, src=0. The round-robin pointer is 0. Slot storage is not cleared. Reset overrides any request in the same cycle.
- Candidate vector: cand = ~full & enable_in. alloc_ready = |cand.
- Accept: alloc_req & alloc_ready at a clock edge.
  - Selected slot s = first set bit of cand.
  - RR_MODE=0: search starts from index 0.
  - RR_MODE=1: search starts from ptr+1 and wraps at STEP_RANGE-1 back to 0. ptr updates to s on every accept.
- On accept, at that edge: full[s]<=1, storage[s]<={alloc_it, alloc_src}, grant_slot<=s, grant_valid<=1. Latency is 1 cycle. grant_valid is a one-cycle pulse per accept.
- alloc_req while alloc_ready=0: no state change, grant_valid<=0. The requester holds or drops at its discretion; there is no queueing.
- Release: release_en & full[release_slot] gives full[release_slot]<=0. Storage is untouched.
- Release of a free slot is ignored, and release_err<=1 for one cycle.
- Simultaneous alloc and release:
  - Selection uses the pre-release full vector, so the released slot is never granted in the same cycle.
  - Net count change is 0.
  - A release to the slot being allocated this cycle cannot occur, because that slot was free, so the release errors.
- count: count + accept − valid_release, computed with DIST_WIDTH+1 bits. It reaches STEP_RANGE exactly when all slots are full.
- Read port: valid, src_it and src are registered from rd_slot at each edge, one-cycle latency.
  - It reflects state before same-edge writes, with no write-through.
  - src_it and src are presented regardless of valid.
- Boundaries:
  - All slots full: alloc_ready=0.
  - enable_in=0: alloc_ready=0 even when empty.
  - Only slot STEP_RANGE-1 free in RR_MODE=1 with ptr=STEP_RANGE-1: the search wraps fully and grants STEP_RANGE-1.
  - Mid-operation reset discards all occupancy and the pending grant_valid.

Decomposition:
- Shared package free_list_pkg:
  - slot index type (DIST_WIDTH)
  - tag type (ITER_WIDTH)
  - word type (WORD_WIDTH)
  - constant STEP_RANGE
  - selection-mode encodings SEL_FIXED=0, SEL_RR=1
- One sub-module: leading_one_select (parametrised width).
  - Combinational one-hot first-set-bit plus binary index and any-bit flag.
  - Round-robin uses it twice: on the mask above ptr, then on the full vector, taking the first hit.

Test Plan:
- Reset, enable_in=all 1, RR_MODE=0, alloc_req high 3 cycles with it=5,6,7 -> grant_slot 0,1,2 on successive cycles; count=3; rd_slot=1 gives next cycle valid=1, src_it=6.
- Fill all 128 slots -> alloc_ready=0, count=128. A further alloc_req leaves grant_valid=0. Release slot 40 with alloc_req same cycle -> no grant that cycle; next-cycle request grants 40.
- enable_in=only bit 99 set -> a single request grants 99, then alloc_ready=0. A second request yields no grant.
- RR_MODE=1: grant 0, release 0, request -> grants 1, not 0. After ptr=127 with only slot 0 free, the search wraps and grants 0.
- Release slot 10 while free -> release_err=1 for one cycle; full and count unchanged.
- Reset asserted during a grant cycle with count=5 -> next cycle full=0, count=0, grant_valid=0, valid=0.
